// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the MIC-1 run/step controller.
package step_ctrl_pkg;

    localparam int STEP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STEP     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

endpackage

// File: rtl/step_ctrl_debounce.sv
// Button debouncer: two-flop synchroniser, then the output follows the input
// once the synchronised level has been stable for DEBOUNCE_CYCLES clocks.
module step_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 10
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic db
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // Any return to the current output level restarts the stability window.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            db      <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            if (sync_p1 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= sync_p1;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// MIC-1 run/single-step/halt controller driving the datapath clock enable.
// Optional step counter enabled by defining STEP_CTRL_STEP_CNT_EN.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  btn_run,
    input  logic                  btn_step,
    input  logic                  btn_halt,
    input  logic                  cpu_halt,
    output logic                  cpu_en,
    output logic                  running,
    output logic [STEP_CNT_W-1:0] step_count
);

    logic   run_db, step_db, halt_db;
    logic   run_db_p1, step_db_p1, halt_db_p1;
    logic   run_rise_p2, step_rise_p2, halt_rise_p2;
    state_t state_q, state_d;
    logic   en_d;

    step_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk(clk), .resetn(resetn), .raw(btn_run), .db(run_db)
    );

    step_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(clk), .resetn(resetn), .raw(btn_step), .db(step_db)
    );

    step_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_halt (
        .clk(clk), .resetn(resetn), .raw(btn_halt), .db(halt_db)
    );

    // p1: previous debounced level; p2: registered rise pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_db_p1    <= 1'b0;
            step_db_p1   <= 1'b0;
            halt_db_p1   <= 1'b0;
            run_rise_p2  <= 1'b0;
            step_rise_p2 <= 1'b0;
            halt_rise_p2 <= 1'b0;
        end else begin
            run_db_p1    <= run_db;
            step_db_p1   <= step_db;
            halt_db_p1   <= halt_db;
            run_rise_p2  <= run_db & ~run_db_p1;
            step_rise_p2 <= step_db & ~step_db_p1;
            halt_rise_p2 <= halt_db & ~halt_db_p1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (halt_rise_p2)                 state_d = IDLE;
                else if (step_rise_p2)            state_d = STEP;
                else if (run_rise_p2 && !cpu_halt) state_d = RUN;
            end
            STEP:     state_d = WAIT_REL;
            WAIT_REL: if (!step_db) state_d = IDLE;
            RUN:      if (halt_rise_p2 || cpu_halt) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        en_d = (state_d == RUN) || (state_d == STEP);
    end

    // Outputs registered with the state so they change in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cpu_en  <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            cpu_en  <= en_d;
            running <= (state_d == RUN);
        end
    end

`ifdef STEP_CTRL_STEP_CNT_EN
    logic [STEP_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (cpu_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign step_count = cnt_q;
`else
    assign step_count = '0;
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl; expected step_count depends on STEP_CTRL_STEP_CNT_EN.
module tb_step_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        btn_run, btn_step, btn_halt, cpu_halt;
    logic        cpu_en, running;
    logic [15:0] step_count;

    int total  = 0;
    int passes = 0;
    int en_cycles = 0;
    int e0;

    step_ctrl #(.DEBOUNCE_CYCLES(10)) dut (
        .clk(clk), .resetn(resetn), .btn_run(btn_run), .btn_step(btn_step),
        .btn_halt(btn_halt), .cpu_halt(cpu_halt), .cpu_en(cpu_en),
        .running(running), .step_count(step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cpu_en === 1'b1) en_cycles <= en_cycles + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] expc(input int n);
`ifdef STEP_CTRL_STEP_CNT_EN
        return 32'(n[15:0]);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(2);
    endtask

    initial begin
        resetn = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_halt = 1'b0; cpu_halt = 1'b0;
        tick(10);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_count", 32'(step_count), 32'd0);
        resetn = 1'b1;
        tick(2);

        // Single step: 2 sync + 10 debounce + 1 edge + 1 FSM = cpu_en 14 cycles after press
        e0 = en_cycles;
        btn_step = 1'b1;
        tick(13);
        check("step_pre", 32'(cpu_en), 32'd0);
        tick(1);
        check("step_en", 32'(cpu_en), 32'd1);
        check("step_running", 32'(running), 32'd0);
        tick(1);
        check("step_one_cycle", 32'(cpu_en), 32'd0);
        check("step_count", 32'(step_count), expc(1));
        tick(15);
        btn_step = 1'b0;
        tick(20);
        check("step_total_en", 32'(en_cycles - e0), 32'd1);

        // Bouncing step button
        do_reset();
        e0 = en_cycles;
        for (int g = 0; g < 2; g++) begin
            btn_step = 1'b1; tick(5);
            btn_step = 1'b0; tick(3);
        end
        check("glitch_no_en", 32'(en_cycles - e0), 32'd0);
        btn_step = 1'b1;
        tick(13);
        check("glitch_pre", 32'(cpu_en), 32'd0);
        tick(1);
        check("glitch_en", 32'(cpu_en), 32'd1);
        tick(16);
        btn_step = 1'b0;
        tick(20);
        check("glitch_total_en", 32'(en_cycles - e0), 32'd1);
        check("glitch_count", 32'(step_count), expc(1));

        // Run for 50 cycles then cpu_halt
        do_reset();
        e0 = en_cycles;
        btn_run = 1'b1;
        tick(14);
        check("run_en", 32'(cpu_en), 32'd1);
        check("run_running", 32'(running), 32'd1);
        tick(6);
        btn_run = 1'b0;
        tick(43);
        check("run_still_en", 32'(cpu_en), 32'd1);
        cpu_halt = 1'b1;
        tick(1);
        check("halt_en_low", 32'(cpu_en), 32'd0);
        check("halt_running", 32'(running), 32'd0);
        check("run_total_en", 32'(en_cycles - e0), 32'd50);
        tick(1);
        check("run_count", 32'(step_count), expc(50));

        // Run press ignored while cpu_halt high
        e0 = en_cycles;
        btn_run = 1'b1;
        tick(25);
        check("run_blocked_en", 32'(en_cycles - e0), 32'd0);
        check("run_blocked_running", 32'(running), 32'd0);
        btn_run = 1'b0;
        cpu_halt = 1'b0;
        tick(20);
        check("run_blocked_after", 32'(running), 32'd0);

        // Halt button exits RUN
        do_reset();
        btn_run = 1'b1;
        tick(14);
        check("hrun_running", 32'(running), 32'd1);
        btn_run = 1'b0;
        tick(5);
        btn_halt = 1'b1;
        tick(13);
        check("hbtn_pre", 32'(cpu_en), 32'd1);
        tick(1);
        check("hbtn_en_low", 32'(cpu_en), 32'd0);
        check("hbtn_running", 32'(running), 32'd0);
        btn_halt = 1'b0;
        tick(20);

        // Run and halt together: halt wins
        do_reset();
        e0 = en_cycles;
        btn_run = 1'b1; btn_halt = 1'b1;
        tick(30);
        check("runhalt_en", 32'(en_cycles - e0), 32'd0);
        check("runhalt_running", 32'(running), 32'd0);
        btn_run = 1'b0; btn_halt = 1'b0;
        tick(20);

        // Step and run together: step wins
        do_reset();
        e0 = en_cycles;
        btn_run = 1'b1; btn_step = 1'b1;
        tick(14);
        check("steprun_en", 32'(cpu_en), 32'd1);
        check("steprun_running", 32'(running), 32'd0);
        tick(16);
        check("steprun_total", 32'(en_cycles - e0), 32'd1);
        btn_run = 1'b0; btn_step = 1'b0;
        tick(20);
        check("steprun_after", 32'(running), 32'd0);

        // Asynchronous reset mid-RUN with run button held through it
        do_reset();
        btn_run = 1'b1;
        tick(20);
        check("arst_pre_en", 32'(cpu_en), 32'd1);
        #3 resetn = 1'b0;
        #1;
        check("arst_en", 32'(cpu_en), 32'd0);
        check("arst_running", 32'(running), 32'd0);
        check("arst_count", 32'(step_count), 32'd0);
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;
        tick(13);
        check("arst_idle", 32'(cpu_en), 32'd0);
        check("arst_count_rel", 32'(step_count), 32'd0);
        tick(1);
        check("arst_rerun", 32'(cpu_en), 32'd1);
        btn_run = 1'b0;
        cpu_halt = 1'b1;
        tick(2);
        cpu_halt = 1'b0;
        tick(20);

`ifdef STEP_CTRL_STEP_CNT_EN
        // Counter wrap: 65535 run cycles, then one step
        do_reset();
        btn_run = 1'b1;
        tick(14);
        tick(65534);
        cpu_halt = 1'b1;
        tick(2);
        check("wrap_ffff", 32'(step_count), 32'h0000_ffff);
        btn_run = 1'b0;
        tick(20);
        cpu_halt = 1'b0;
        btn_step = 1'b1;
        tick(30);
        btn_step = 1'b0;
        tick(20);
        check("wrap_zero", 32'(step_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 10, number of stable clk cycles before a button input is accepted.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 btn_run  input  1  raw run button, asynchronous, bouncing.
REQ-005 btn_step  input  1  raw single-step button, asynchronous, bouncing.
REQ-006 btn_halt  input  1  raw halt button, asynchronous, bouncing.
REQ-007 cpu_halt  input  1  level from MIC-1 datapath, high when the HALT microinstruction is reached.
REQ-008 cpu_en  output  1  registered clock enable to the MIC-1 datapath.
REQ-009 running  output  1  registered, high while in RUN.
REQ-010 step_count  output  16  count of cpu_en cycles issued (see Configuration).

Function
REQ-011 Each button SHALL pass through its own debouncer; the debounced output follows the raw input once the raw input has been stable for DEBOUNCE_CYCLES cycles.
REQ-012 A one-cycle rise pulse SHALL be generated per debounced output from a registered previous value; falling edges produce no pulse.
REQ-013 States: IDLE, RUN, STEP, WAIT_REL; the state register SHALL be encoded with the package enum.
REQ-014 IDLE: halt_rise -> IDLE; else step_rise -> STEP; else run_rise with cpu_halt low -> RUN; run_rise with cpu_halt high SHALL be ignored.
REQ-015 STEP: cpu_en high for exactly one cycle; next state WAIT_REL unconditionally.
REQ-016 WAIT_REL: cpu_en low; SHALL return to IDLE only when debounced step is low; other rise pulses in this state are discarded.
REQ-017 RUN: cpu_en high every cycle; halt_rise or cpu_halt high -> IDLE; step_rise and run_rise ignored.
REQ-018 Priority when pulses coincide: halt > step > run.
REQ-019 Latency: debounced rise at cycle k -> rise pulse at k+1 -> cpu_en first high at k+2; RUN exit: cpu_halt high at cycle k -> cpu_en low from k+1.
REQ-020 running SHALL equal (state == RUN), registered alongside cpu_en.

Reset
REQ-021 resetn low SHALL force state IDLE, cpu_en 0, running 0, step_count 0, edge registers 0 immediately, independent of clk.
REQ-022 Debouncer instances SHALL reset to output 0; a button held through reset release produces one rise after DEBOUNCE_CYCLES.
REQ-023 Reset asserted mid-RUN or mid-STEP SHALL drop cpu_en in the same instant; no partial step is completed after release.

Configuration
REQ-024 Macro STEP_CTRL_STEP_CNT_EN: when defined, step_count increments by 1 on every cycle with cpu_en high, wrapping 0xFFFF -> 0x0000.
REQ-025 Without STEP_CTRL_STEP_CNT_EN, step_count SHALL be driven constant 0 and no counter register is synthesized; all other behaviour identical.

Structure
REQ-026 Package step_ctrl_pkg SHALL hold the state enum typedef (IDLE, RUN, STEP, WAIT_REL) and constant STEP_CNT_W = 16.
REQ-027 Sub-module: the existing debouncer, instanced three times with parameter DEBOUNCE_CYCLES; edge detect and FSM stay in step_ctrl.

Verification
REQ-028 Reset 10 cycles, btn_step pulse held 30 cycles -> exactly one cpu_en cycle, at debounced rise + 2; step_count 0 -> 1.
REQ-029 btn_step with 5-cycle bounce glitches (< 10) before settling high -> still exactly one cpu_en cycle; step_count 1.
REQ-030 btn_run held 20 cycles, then cpu_halt high after 50 cpu_en cycles -> cpu_en low next cycle, running 0, step_count 50.
REQ-031 btn_run and btn_halt released/asserted together, both debounce same cycle -> state stays IDLE, cpu_en never high.
REQ-032 In RUN, resetn pulsed low for 3 cycles asynchronously -> cpu_en 0 within the reset window, state IDLE, step_count 0 after release.
REQ-033 With macro defined, preload via 65535 steps then one more step -> step_count wraps to 0x0000; without macro step_count stays 0 throughout.
